bcd_to_binary: RTL and testbench

Converts a packed two-digit BCD value into an unsigned binary value through a single registered stage. It sits at the boundary between decimal-coded sources (keypad/display logic) and binary datapath logic. It flags malformed BCD digits and results that do not fit the output width.

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_digit_check.sv | 14 +
 rtl/bcd_to_binary.sv | 87 ++++++++
 tb/tb_bcd_to_binary.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD-to-binary converter.
package bcd_pkg;

   // Largest legal value of a single BCD digit.
   localparam int BCD_DIGIT_MAX = 9;

   // Working width of the conversion arithmetic. The top level masks results
   // down to the internal width, so this only needs to be wide enough for it.
   localparam int BCD_ACC_W = 32;

   typedef logic [BCD_ACC_W-1:0] bcd_acc_t;

   // Multiply by ten as (x << 3) + (x << 1).
   function automatic bcd_acc_t mul10(input bcd_acc_t x);
      return (x << 3) + (x << 1);
   endfunction

   // Bits needed to hold any value of num_digits BCD digits:
   // ceil(log2(10^num_digits)).
   function automatic int calc_int_w(input int num_digits);
      longint unsigned span;
      int              w;
      span = 1;
      for (int i = 0; i < num_digits; i++) begin
         span = span * 10;
      end
      w = 0;
      while ((64'd1 << w) < span) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// Flags whether one 4-bit nibble is a legal BCD digit (0..9).
module bcd_digit_check
   import bcd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic       valid
);

   // Legal when the nibble does not exceed the largest decimal digit.
   always_comb begin
      valid = (nibble <= 4'(BCD_DIGIT_MAX));
   end

endmodule

// File: rtl/bcd_to_binary.sv
// Registered packed-BCD to unsigned binary converter with digit and
// overflow flags. There is no handshake: in is sampled on every rising
// edge and out/err_digit/err_ovf always describe that single sample.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int OUT_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] in,
   output logic [OUT_W-1:0]        out,
   output logic                    err_digit,
   output logic                    err_ovf
);

   // Internal width that can hold the largest BCD value without truncation.
   localparam int INT_W = calc_int_w(NUM_DIGITS);

   localparam bcd_acc_t INT_MASK =
      (INT_W >= BCD_ACC_W) ? '1 : bcd_acc_t'((64'd1 << INT_W) - 64'd1);

   localparam bcd_acc_t OUT_MAX =
      (OUT_W >= BCD_ACC_W) ? '1 : bcd_acc_t'((64'd1 << OUT_W) - 64'd1);

   logic [NUM_DIGITS-1:0] digit_valid;
   bcd_acc_t              value;
   logic                  all_valid;
   logic                  too_big;

   logic [OUT_W-1:0]      out_d,       out_q;
   logic                  err_digit_d, err_digit_q;
   logic                  err_ovf_d,   err_ovf_q;

   // One legality checker per digit.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_check u_check (
         .nibble (in[4*g +: 4]),
         .valid  (digit_valid[g])
      );
   end

   // Horner accumulation, most significant digit first: acc = acc*10 + digit.
   always_comb begin
      bcd_acc_t acc;
      acc = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc = (mul10(acc) + bcd_acc_t'(in[4*i +: 4])) & INT_MASK;
      end
      value = acc;
   end

   // Next outputs: bad digit beats overflow, overflow saturates.
   always_comb begin
      all_valid   = &digit_valid;
      too_big     = (value > OUT_MAX);
      out_d       = value[OUT_W-1:0];
      err_digit_d = 1'b0;
      err_ovf_d   = 1'b0;
      if (!all_valid) begin
         out_d       = '0;
         err_digit_d = 1'b1;
      end else if (too_big) begin
         out_d     = '1;
         err_ovf_d = 1'b1;
      end
   end

   // Output register; all three outputs load together so they never mix samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         err_digit_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         out_q       <= out_d;
         err_digit_q <= err_digit_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign out       = out_q;
   assign err_digit = err_digit_q;
   assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: reset, table-driven vectors, hand-written
// multi-cycle corner cases and randomized checks against a decimal model.
module tb_bcd_to_binary;

   // ---------------------------------------------------------------- clock/reset
   logic       clk;
   logic       rst_n;
   logic [7:0] in_r;
   logic [3:0] out;
   logic       err_digit;
   logic       err_ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bcd_to_binary #(.NUM_DIGITS(2), .OUT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_r),
      .out       (out),
      .err_digit (err_digit),
      .err_ovf   (err_ovf)
   );

   // Observed result packed as {out, err_digit, err_ovf}.
   logic [5:0] dut_bits;
   assign dut_bits = {out, err_digit, err_ovf};

   // ---------------------------------------------------------------- scoreboard
   int         n_checks;
   int         n_fail;
   logic [5:0] exp_prev;
   logic [5:0] exp_q[$];

   function automatic logic [5:0] pack_exp(input logic [3:0] o, input logic ed, input logic eo);
      return {o, ed, eo};
   endfunction

   // Decimal reference: read the two digits, do plain arithmetic, then apply
   // the bad-digit / saturation rules.
   function automatic logic [5:0] ref_model(input logic [7:0] v);
      int tens;
      int ones;
      int val;
      tens = int'(v[7:4]);
      ones = int'(v[3:0]);
      if (tens > 9 || ones > 9) return pack_exp(4'd0, 1'b1, 1'b0);
      val = tens * 10 + ones;
      if (val > 15) return pack_exp(4'hF, 1'b0, 1'b1);
      return pack_exp(4'(val), 1'b0, 1'b0);
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got out=%0d err_digit=%b err_ovf=%b, want out=%0d err_digit=%b err_ovf=%b",
                  name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
      end
   endtask

   // ---------------------------------------------------------------- driver
   // Called 1 time unit after a rising edge. Drives v, confirms the previous
   // result still holds before the next edge, then checks the new result
   // just after that edge.
   task automatic apply(input logic [7:0] v, input logic [5:0] exp, input string name);
      in_r = v;
      #2;
      check({name, "_hold"}, dut_bits, exp_prev);
      @(posedge clk);
      #1;
      check(name, dut_bits, exp);
      exp_prev = exp;
   endtask

   typedef struct {
      logic [7:0] in_v;
      logic [3:0] out_v;
      logic       ed;
      logic       eo;
   } vec_t;

   vec_t vecs[25];

   // ---------------------------------------------------------------- test
   initial begin
      logic [7:0] rv;
      logic [5:0] e;
      n_checks = 0;
      n_fail   = 0;
      exp_prev = 6'd0;

      // Table: BCD 00..15 sweep, overflow, invalid digits and recovery.
      for (int i = 0; i < 16; i++) begin
         vecs[i].in_v  = 8'((i / 10) * 16 + (i % 10));
         vecs[i].out_v = 4'(i);
         vecs[i].ed    = 1'b0;
         vecs[i].eo    = 1'b0;
      end
      vecs[16] = '{8'h16, 4'hF, 1'b0, 1'b1};
      vecs[17] = '{8'h99, 4'hF, 1'b0, 1'b1};
      vecs[18] = '{8'h12, 4'd12, 1'b0, 1'b0};
      vecs[19] = '{8'h1A, 4'd0, 1'b1, 1'b0};
      vecs[20] = '{8'hA0, 4'd0, 1'b1, 1'b0};
      vecs[21] = '{8'h07, 4'd7, 1'b0, 1'b0};
      vecs[22] = '{8'hFF, 4'd0, 1'b1, 1'b0};
      vecs[23] = '{8'h9A, 4'd0, 1'b1, 1'b0};
      vecs[24] = '{8'h15, 4'd15, 1'b0, 1'b0};

      // Reset asserted with no clock edge involved.
      rst_n = 1'b1;
      in_r  = 8'h15;
      #1 rst_n = 1'b0;
      #2;
      check("reset_async", dut_bits, 6'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", dut_bits, 6'd0);
      rst_n = 1'b0;

      // Release and first conversions.
      rst_n = 1'b1;
      apply(8'h00, pack_exp(4'd0, 1'b0, 1'b0), "first_00");
      apply(8'h09, pack_exp(4'd9, 1'b0, 1'b0), "first_09");

      // Table-driven back-to-back vectors.
      for (int i = 0; i < 25; i++) begin
         apply(vecs[i].in_v, pack_exp(vecs[i].out_v, vecs[i].ed, vecs[i].eo),
               $sformatf("vec%0d_%02h", i, vecs[i].in_v));
      end

      // Mid-stream asynchronous reset pulse between edges.
      apply(8'h13, pack_exp(4'd13, 1'b0, 1'b0), "stream13_a");
      apply(8'h13, pack_exp(4'd13, 1'b0, 1'b0), "stream13_b");
      #2 rst_n = 1'b0;
      #1;
      check("midreset_immediate", dut_bits, 6'd0);
      #2 rst_n = 1'b1;
      #1;
      check("midreset_released", dut_bits, 6'd0);
      @(posedge clk);
      #1;
      check("midreset_recover13", dut_bits, pack_exp(4'd13, 1'b0, 1'b0));
      exp_prev = pack_exp(4'd13, 1'b0, 1'b0);

      // Glitches between edges: only the value at the edge counts.
      in_r = 8'h05;
      #1 in_r = 8'h99;
      #1 in_r = 8'h1A;
      #1 in_r = 8'h14;
      #1 in_r = 8'hB3;
      #1;
      check("glitch_hold", dut_bits, exp_prev);
      in_r = 8'h03;
      @(posedge clk);
      #1;
      check("glitch_edge03", dut_bits, pack_exp(4'd3, 1'b0, 1'b0));
      exp_prev = pack_exp(4'd3, 1'b0, 1'b0);

      // Randomized stimulus: expectations queued from the model, popped
      // one cycle later.
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) begin
            rv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end else begin
            rv = 8'($urandom_range(0, 255));
         end
         exp_q.push_back(ref_model(rv));
         in_r = rv;
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("rand%0d_%02h", i, rv), dut_bits, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
